// File: rtl/draw_scheduler_pkg.sv
// Shared types and constants for the draw scheduler: FSM states, job kinds,
// image dimensions, ROM select codes and the transparency colour key.
package draw_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  typedef enum logic {
    JOB_SCREEN = 1'b0,
    JOB_SPRITE = 1'b1
  } job_e;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 40;
  localparam int SPRITE_H = 40;

  localparam logic [2:0] TRANSP_COL = 3'b101;

  localparam logic [4:0] SEL_TITLE   = 5'd0;
  localparam logic [4:0] SEL_CHOOSE  = 5'd1;
  localparam logic [4:0] SEL_DOG     = 5'd2;
  localparam logic [4:0] SEL_CAT     = 5'd3;
  localparam logic [4:0] SEL_CHICKEN = 5'd4;

  // Widened sums let sprites hang off the right/bottom edge without wrapping.
  function automatic logic in_screen(input logic [8:0] x9, input logic [7:0] y8);
    return (x9 < 9'(SCREEN_W)) && (y8 < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/draw_scheduler_pipe_delay.sv
// LAT-deep shift register that keeps {valid,x,y} aligned with ROM read data.
// Synchronous clear empties every stage.
module draw_scheduler_pipe_delay #(
  parameter int LAT    = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] stage_q [LAT];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[LAT-1];

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates background and sprite draws onto the VGA plot path and scans ROM addresses.
// Optional feature macro: DRAW_TRANSPARENT_EN (sprite pixels equal to TRANSP_COL are not plotted).
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screenReq,
  input  logic [4:0]  screenSel,
  input  logic        spriteReq,
  input  logic [4:0]  spriteSel,
  input  logic [7:0]  spriteX,
  input  logic [6:0]  spriteY,
  input  logic [2:0]  colourIn,
  output logic [14:0] romAddr,
  output logic [4:0]  memorySel,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colourOut,
  output logic        plot,
  output logic        busy,
  output logic        screenDone,
  output logic        spriteDone
);

  localparam int PIPE_W = 16;

  state_e      state_q, state_d;
  job_e        job_q, job_d;
  logic [4:0]  sel_q, sel_d;
  logic [7:0]  orig_x_q, orig_x_d;
  logic [6:0]  orig_y_q, orig_y_d;
  logic [7:0]  dim_w_q, dim_w_d;
  logic [6:0]  dim_h_q, dim_h_d;
  logic [7:0]  col_q, col_d;
  logic [6:0]  row_q, row_d;
  logic [14:0] addr_q, addr_d;
  logic [1:0]  drain_q, drain_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      job_q    <= JOB_SCREEN;
      sel_q    <= '0;
      orig_x_q <= '0;
      orig_y_q <= '0;
      dim_w_q  <= '0;
      dim_h_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      sel_q    <= sel_d;
      orig_x_q <= orig_x_d;
      orig_y_q <= orig_y_d;
      dim_w_q  <= dim_w_d;
      dim_h_q  <= dim_h_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    sel_d    = sel_q;
    orig_x_d = orig_x_q;
    orig_y_d = orig_y_q;
    dim_w_d  = dim_w_q;
    dim_h_d  = dim_h_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    drain_d  = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        // Screen wins a tie; a held spriteReq is picked up on a later IDLE cycle.
        if (screenReq) begin
          job_d   = JOB_SCREEN;
          state_d = ST_LOAD;
        end else if (spriteReq) begin
          job_d   = JOB_SPRITE;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (job_q == JOB_SCREEN) begin
          sel_d    = screenSel;
          orig_x_d = '0;
          orig_y_d = '0;
          dim_w_d  = 8'(SCREEN_W);
          dim_h_d  = 7'(SCREEN_H);
        end else begin
          sel_d    = spriteSel;
          orig_x_d = spriteX;
          orig_y_d = spriteY;
          dim_w_d  = 8'(SPRITE_W);
          dim_h_d  = 7'(SPRITE_H);
        end
        col_d   = '0;
        row_d   = '0;
        addr_d  = '0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Running address equals row*W+col without a multiplier.
        addr_d = addr_q + 15'd1;
        if (col_q == dim_w_q - 8'd1) begin
          col_d = '0;
          if (row_q == dim_h_q - 7'd1) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end else begin
            row_d = row_q + 7'd1;
          end
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'(ROM_LAT - 1)) state_d = ST_FINISH;
        else                            drain_d = drain_q + 2'd1;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Scan stage: pixel position and clip decision travel with the ROM request.
  logic [8:0]        pix_x;
  logic [7:0]        pix_y;
  logic              pix_vld;
  logic [PIPE_W-1:0] pipe_q;
  logic              pipe_vld;

  assign pix_x   = {1'b0, orig_x_q} + {1'b0, col_q};
  assign pix_y   = {1'b0, orig_y_q} + {1'b0, row_q};
  assign pix_vld = (state_q == ST_SCAN) && in_screen(pix_x, pix_y);

  draw_scheduler_pipe_delay #(
    .LAT    (ROM_LAT),
    .DATA_W (PIPE_W)
  ) u_pipe (
    .clk_i (clk),
    .clr_i (reset),
    .d_i   ({pix_vld, pix_x[7:0], pix_y[6:0]}),
    .q_o   (pipe_q)
  );

  // Output stage: ROM data arrives together with the delayed position.
  assign pipe_vld  = pipe_q[15];
  assign x         = pipe_q[14:7];
  assign y         = pipe_q[6:0];
  assign colourOut = pipe_vld ? colourIn : 3'd0;

`ifdef DRAW_TRANSPARENT_EN
  assign plot = pipe_vld && !((job_q == JOB_SPRITE) && (colourIn == TRANSP_COL));
`else
  assign plot = pipe_vld;
`endif

  assign romAddr    = (state_q == ST_SCAN) ? addr_q : '0;
  assign memorySel  = sel_q;
  assign busy       = (state_q != ST_IDLE);
  assign screenDone = (state_q == ST_FINISH) && (job_q == JOB_SCREEN);
  assign spriteDone = (state_q == ST_FINISH) && (job_q == JOB_SPRITE);

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomised bench for draw_scheduler: a cycle-level reference built from the
// scan/latency rules checks every busy cycle of every job against the DUT.
module tb_draw_scheduler;

  localparam int ROM_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        screenReq, spriteReq;
  logic [4:0]  screenSel, spriteSel;
  logic [7:0]  spriteX;
  logic [6:0]  spriteY;
  logic [2:0]  colourIn;
  logic [14:0] romAddr;
  logic [4:0]  memorySel;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colourOut;
  logic        plot, busy, screenDone, spriteDone;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [14:0] salt;

  draw_scheduler #(.ROM_LAT(ROM_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .screenReq  (screenReq),
    .screenSel  (screenSel),
    .spriteReq  (spriteReq),
    .spriteSel  (spriteSel),
    .spriteX    (spriteX),
    .spriteY    (spriteY),
    .colourIn   (colourIn),
    .romAddr    (romAddr),
    .memorySel  (memorySel),
    .x          (x),
    .y          (y),
    .colourOut  (colourOut),
    .plot       (plot),
    .busy       (busy),
    .screenDone (screenDone),
    .spriteDone (spriteDone)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_f(input logic [4:0] s, input logic [14:0] a);
    logic [14:0] t;
    t = a ^ (a >> 3) ^ (a >> 7) ^ {10'd0, s} ^ salt;
    return t[2:0];
  endfunction

  // ROM model: data depends on the selected image and the address, ROM_LAT cycles late.
  logic [2:0] rom_q [ROM_LAT];
  always @(posedge clk) begin
    rom_q[0] <= rom_f(memorySel, romAddr);
    for (int i = 1; i < ROM_LAT; i++) rom_q[i] <= rom_q[i-1];
  end
  assign colourIn = rom_q[ROM_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expects the request already raised; checks every cycle from LOAD through FINISH.
  task automatic run_job(input bit scr, input logic [4:0] sel, input logic [7:0] ox,
                         input logic [6:0] oy, output int nplots);
    int w, h, len, waited, p, xs, ys;
    bit granted, pe;
    logic [2:0]  ce;
    logic [36:0] exp_w, obs_w;
    w = scr ? 160 : 40;
    h = scr ? 120 : 40;
    len = 2 + w * h + ROM_LAT;
    nplots = 0;
    granted = 0;
    waited = 0;
    while (!granted && waited < 8) begin
      @(negedge clk);
      waited++;
      if (busy) granted = 1;
    end
    chk(scr ? "scr_grant_lat" : "spr_grant_lat", 64'(waited), 64'd1);
    if (granted) begin
      for (int k = 0; k < len; k++) begin
        if (k > 0) @(negedge clk);
        p  = k - 1 - ROM_LAT;
        pe = 0;
        xs = 0;
        ys = 0;
        ce = 3'd0;
        if (p >= 0 && p < w * h) begin
          xs = ox + (p % w);
          ys = oy + (p / w);
          ce = rom_f(sel, 15'(p));
          pe = (xs < 160) && (ys < 120);
`ifdef DRAW_TRANSPARENT_EN
          if (!scr && ce == 3'b101) pe = 0;
`endif
        end
        exp_w = {15'((k >= 1 && k <= w * h) ? k - 1 : 0), 1'b1,
                 (k == len - 1) && scr, (k == len - 1) && !scr, pe,
                 pe ? {8'(xs), 7'(ys), ce} : 18'd0};
        obs_w = {romAddr, busy, screenDone, spriteDone, plot,
                 plot ? {x, y, colourOut} : 18'd0};
        chk(scr ? "scr_trace" : "spr_trace", 64'(obs_w), 64'(exp_w));
        if (k == 1) chk("memsel", 64'(memorySel), 64'(sel));
        if (plot) nplots++;
        if (screenDone) screenReq = 1'b0;
        if (spriteDone) spriteReq = 1'b0;
      end
    end
    if (scr) screenReq = 1'b0;
    else     spriteReq = 1'b0;
    @(negedge clk);
    chk("idle_after_job", 64'({busy, screenDone, spriteDone, plot}), 64'd0);
  endtask

  initial begin
    int  n, waited;
    bit  hit;
    logic [4:0] rsel;
    salt      = 15'($urandom);
    reset     = 1'b1;
    screenReq = 1'b1;
    screenSel = 5'd3;
    spriteReq = 1'b1;
    spriteSel = 5'd7;
    spriteX   = 8'd60;
    spriteY   = 7'd40;

    // Reset held with both requests high: every output stays 0.
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", 64'({romAddr, memorySel, x, y, colourOut, plot, busy, screenDone, spriteDone}),
          64'd0);
    end
    reset = 1'b0;

    // Simultaneous requests: full screen first, then the pending sprite.
    run_job(1'b1, 5'd3, 8'd0, 7'd0, n);
    chk("scr_plots", 64'(n), 64'd19200);
    run_job(1'b0, 5'd7, 8'd60, 7'd40, n);
`ifndef DRAW_TRANSPARENT_EN
    chk("spr_plots_60_40", 64'(n), 64'd1600);
`endif

    // Sprite clipped at the bottom-right corner.
    spriteSel = 5'd2; spriteX = 8'd140; spriteY = 7'd100; spriteReq = 1'b1;
    run_job(1'b0, 5'd2, 8'd140, 7'd100, n);
`ifndef DRAW_TRANSPARENT_EN
    chk("spr_plots_clip", 64'(n), 64'd400);
`endif

    // Sprite touching the right/bottom edges exactly.
    spriteSel = 5'd4; spriteX = 8'd120; spriteY = 7'd80; spriteReq = 1'b1;
    run_job(1'b0, 5'd4, 8'd120, 7'd80, n);
`ifndef DRAW_TRANSPARENT_EN
    chk("spr_plots_edge", 64'(n), 64'd1600);
`endif

    for (int i = 0; i < 4; i++) begin
      rsel      = 5'($urandom);
      spriteSel = rsel;
      spriteX   = 8'($urandom_range(0, 255));
      spriteY   = 7'($urandom_range(0, 127));
      spriteReq = 1'b1;
      run_job(1'b0, rsel, spriteX, spriteY, n);
    end

    // Reset in the middle of a screen job aborts it without a done pulse.
    screenSel = 5'd1;
    screenReq = 1'b1;
    hit = 0;
    waited = 0;
    while (!hit && waited < 8) begin
      @(negedge clk);
      waited++;
      if (busy) hit = 1;
    end
    chk("mid_grant", 64'(hit), 64'd1);
    repeat (5000) @(negedge clk);
    reset     = 1'b1;
    screenReq = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", 64'({romAddr, plot, busy, screenDone, spriteDone}), 64'd0);
    @(negedge clk);
    chk("mid_rst_hold", 64'({plot, busy, screenDone, spriteDone}), 64'd0);
    reset = 1'b0;

    rsel      = 5'($urandom);
    spriteSel = rsel;
    spriteX   = 8'($urandom_range(0, 159));
    spriteY   = 7'($urandom_range(0, 119));
    spriteReq = 1'b1;
    run_job(1'b0, rsel, spriteX, spriteY, n);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
